// File: rtl/unary_add_nch.sv
// unary_add_nch: multi-operand unary (thermometer-stream) adder.
// Read phase counts the 1-bits of NCH serial unary streams into a CNT_W-bit
// accumulator; write phase re-emits the total on dout as a run of 1s followed
// by a one-cycle done pulse. C is a sticky overflow flag.
// Build option: define UNARY_ADD_SAT_EN to saturate the accumulator at
// 2^CNT_W-1 on overflow; otherwise it wraps modulo 2^CNT_W.
module unary_add_nch #(
  parameter int NCH   = 2,
  parameter int CNT_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic           read_or_write,
  input  logic [NCH-1:0] din,
  output logic           dout,
  output logic           C,
  output logic           busy,
  output logic           done
);

  // Popcount width and a sum width wide enough to hold acc + popcount exactly.
  localparam int PC_W  = $clog2(NCH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  localparam logic [1:0] S_ACC  = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic             c_nxt;
  logic             dout_nxt;
  logic             done_nxt;

  logic [PC_W-1:0]  pop;
  logic [SUM_W-1:0] sum;
  logic             ovf;
  logic [CNT_W-1:0] acc_add;

  // Count the set bits across all input streams for this cycle.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      pop = pop + PC_W'(din[i]);
    end
  end

  // Exact sum, overflow detect, and the accumulator value to store.
  always_comb begin
    sum = SUM_W'(acc) + SUM_W'(pop);
    ovf = (sum > SUM_W'(ACC_MAX));
`ifdef UNARY_ADD_SAT_EN
    acc_add = ovf ? ACC_MAX : sum[CNT_W-1:0];
`else
    acc_add = sum[CNT_W-1:0];
`endif
  end

  // Next-state and next-output decode; dout and done default low so both
  // only ever reflect the cycle they were produced in.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    c_nxt     = C;
    dout_nxt  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_ACC: begin
        if (en) begin
          if (!read_or_write) begin
            acc_nxt = acc_add;
            if (ovf) begin
              c_nxt = 1'b1;
            end
          end else begin
            rem_nxt   = acc;
            state_nxt = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (en) begin
          if (rem != '0) begin
            dout_nxt = 1'b1;
            rem_nxt  = rem - CNT_W'(1);
          end else begin
            done_nxt  = 1'b1;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (en && !read_or_write) begin
          acc_nxt   = '0;
          c_nxt     = 1'b0;
          state_nxt = S_ACC;
        end
      end
      default: begin
        state_nxt = S_ACC;
      end
    endcase
  end

  // State, datapath and output registers; busy is registered from the
  // next-state so it tracks S_EMIT without decoding after the flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_ACC;
      acc   <= '0;
      rem   <= '0;
      C     <= 1'b0;
      dout  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      rem   <= rem_nxt;
      C     <= c_nxt;
      dout  <= dout_nxt;
      done  <= done_nxt;
      busy  <= (state_nxt == S_EMIT);
    end
  end

endmodule

// File: tb/tb_unary_add_nch.sv
// Self-checking bench for unary_add_nch (NCH=2 and NCH=3, CNT_W=4).
module tb_unary_add_nch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, rw;
  logic [1:0] din;
  logic       dout, c, busy, done;

  logic       en3, rw3;
  logic [2:0] din3;
  logic       dout3, c3, busy3, done3;

  int checks = 0;
  int passed = 0;
  int sum    = 0;

  typedef struct packed {
    logic d;
    logic dn;
    logic b;
  } obs_t;

  always #5 clk = ~clk;

  unary_add_nch #(.NCH(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .read_or_write(rw), .din(din),
    .dout(dout), .C(c), .busy(busy), .done(done)
  );

  unary_add_nch #(.NCH(3), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .read_or_write(rw3), .din(din3),
    .dout(dout3), .C(c3), .busy(busy3), .done(done3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Length of the emitted run for a given true sum.
  function automatic int run_len(input int s);
`ifdef UNARY_ADD_SAT_EN
    return (s > 15) ? 15 : s;
`else
    return s % 16;
`endif
  endfunction

  task automatic acc_cycle(input logic [1:0] d, input logic e);
    en = e; rw = 1'b0; din = d;
    step();
    if (e) sum += $countones(d);
    chk("acc_C", c, (sum > 15));
    chk("acc_dout", dout, 1'b0);
    chk("acc_busy", busy, 1'b0);
    chk("acc_done", done, 1'b0);
  endtask

  task automatic hold_to_acc();
    en = 1'b1; rw = 1'b0; din = 2'($urandom);
    step();
    sum = 0;
    chk("clr_C", c, 1'b0);
    chk("clr_busy", busy, 1'b0);
    chk("clr_dout", dout, 1'b0);
  endtask

  // Start an emission and check every cycle against the expected trace,
  // with en low for pause_len edges starting at trace index pause_at.
  task automatic emit(input int pause_at, input int pause_len);
    obs_t q[$];
    int   n;
    int   ones;
    int   i;
    logic cexp;
    n    = run_len(sum);
    cexp = (sum > 15);
    ones = 0;
    i    = 0;
    while (1) begin
      if (i >= pause_at && i < pause_at + pause_len) q.push_back('{d:1'b0, dn:1'b0, b:1'b1});
      else if (ones < n) begin q.push_back('{d:1'b1, dn:1'b0, b:1'b1}); ones++; end
      else begin q.push_back('{d:1'b0, dn:1'b1, b:1'b0}); break; end
      i++;
    end
    en = 1'b1; rw = 1'b1; din = 2'($urandom);
    step();
    chk("start_busy", busy, 1'b1);
    chk("start_dout", dout, 1'b0);
    chk("start_done", done, 1'b0);
    chk("start_C", c, cexp);
    foreach (q[j]) begin
      en  = !(j >= pause_at && j < pause_at + pause_len);
      rw  = 1'($urandom);
      din = 2'($urandom);
      step();
      chk("emit_dout", dout, q[j].d);
      chk("emit_done", done, q[j].dn);
      chk("emit_busy", busy, q[j].b);
      chk("emit_C", c, cexp);
    end
    en = 1'b1; rw = 1'b1;
    step();
    chk("hold_done", done, 1'b0);
    chk("hold_dout", dout, 1'b0);
    chk("hold_busy", busy, 1'b0);
    chk("hold_C", c, cexp);
  endtask

  // Async reset part-way through an emission.
  task automatic reset_mid(input int ones_before);
    en = 1'b1; rw = 1'b1;
    step();
    rw = 1'b0;
    for (int k = 0; k < ones_before; k++) begin
      step();
      chk("mid_dout", dout, 1'b1);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_dout", dout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_C", c, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sum = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp3;
    logic [2:0] pat3 [4];
    rst_n = 1'b0; en = 1'b0; rw = 1'b0; din = '0;
    en3 = 1'b0; rw3 = 1'b0; din3 = '0;
    #12;
    chk("reset_dout", dout, 1'b0);
    chk("reset_C", c, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst_n = 1'b1;

    // Sum 9 with one disabled accumulate cycle in between.
    repeat (4) acc_cycle(2'b11, 1'b1);
    acc_cycle(2'b11, 1'b0);
    acc_cycle(2'b01, 1'b1);
    chk("sum9", sum, 9);
    emit(99, 0);

    // Overflow: 18 ones.
    hold_to_acc();
    repeat (9) acc_cycle(2'b11, 1'b1);
    emit(99, 0);

    // Zero sum.
    hold_to_acc();
    emit(99, 0);

    // Pause of 3 after the 2nd one.
    hold_to_acc();
    acc_cycle(2'b11, 1'b1);
    acc_cycle(2'b11, 1'b1);
    acc_cycle(2'b10, 1'b1);
    emit(2, 3);

    // Randomised runs.
    repeat (10) begin
      int k;
      hold_to_acc();
      k = $urandom_range(0, 11);
      repeat (k) acc_cycle(2'($urandom), ($urandom_range(0, 3) != 0));
      emit($urandom_range(0, 6), $urandom_range(0, 3));
    end

    // Reset after the 3rd of 6 ones, then accumulate 2.
    hold_to_acc();
    repeat (3) acc_cycle(2'b11, 1'b1);
    reset_mid(3);
    acc_cycle(2'b11, 1'b1);
    emit(99, 0);

    // Reset during an overflowed emission clears C; then zero sum from reset.
    hold_to_acc();
    repeat (9) acc_cycle(2'b11, 1'b1);
    reset_mid(1);
    emit(99, 0);

    // NCH=3 stream.
    pat3[0] = 3'b111; pat3[1] = 3'b101; pat3[2] = 3'b000; pat3[3] = 3'b011;
    exp3 = 0;
    en3 = 1'b1; rw3 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din3 = pat3[k];
      exp3 += $countones(pat3[k]);
      step();
    end
    rw3 = 1'b1;
    step();
    chk("n3_start_busy", busy3, 1'b1);
    for (int k = 0; k < exp3; k++) begin
      rw3 = k[0];
      din3 = 3'($urandom);
      step();
      chk("n3_dout", dout3, 1'b1);
      chk("n3_busy", busy3, 1'b1);
    end
    step();
    chk("n3_done", done3, 1'b1);
    chk("n3_end_dout", dout3, 1'b0);
    chk("n3_end_busy", busy3, 1'b0);
    step();
    chk("n3_done_pulse", done3, 1'b0);
    chk("n3_C", c3, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
